// File: rtl/eta_sched_pkg.sv
// eta_add_sched shared types and defaults.
// State encoding, width defaults and counter sizing.
package eta_sched_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int KEY_W_DEF  = 32;
  localparam int CNT_W_DEF  = $clog2(KEY_W_DEF + 1);
  localparam int LAT_W      = 4;

  typedef enum logic [1:0] {
    KEY_LOAD,
    IDLE,
    WAIT,
    RESP
  } state_e;

  function automatic int cnt_w(input int key_w);
    return $clog2(key_w + 1);
  endfunction

endpackage

// File: rtl/eta_add_sched_if.sv
// Requester/response bundle for eta_add_sched.
// master = requesters + response sink, slave = scheduler.
interface eta_add_sched_if
  import eta_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0_vld;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req0_rdy;
  logic              req1_vld;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              req1_rdy;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic              rsp_id;
  logic [DATA_W:0]   rsp_sum;

  modport master (
    output req0_vld, req0_a, req0_b,
    output req1_vld, req1_a, req1_b,
    output rsp_rdy,
    input  req0_rdy, req1_rdy,
    input  rsp_vld, rsp_id, rsp_sum
  );

  modport slave (
    input  req0_vld, req0_a, req0_b,
    input  req1_vld, req1_a, req1_b,
    input  rsp_rdy,
    output req0_rdy, req1_rdy,
    output rsp_vld, rsp_id, rsp_sum
  );

endinterface

// File: rtl/eta_key_loader.sv
// Serial MSB-first key shifter with bit counter and lock flag.
// A reload restarts the count with the current bit as the first one.
module eta_key_loader
  import eta_sched_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_bit,
  input  logic             key_vld,
  input  logic             reload,
  output logic [KEY_W-1:0] key,
  output logic             locked,
  output logic             lock_now
);

  localparam int CW = cnt_w(KEY_W);

  logic [CW-1:0] cnt;
  logic [CW-1:0] base;
  logic          shift_en;

  assign shift_en = reload | (~locked & key_vld);
  assign base     = reload ? '0 : cnt;
  assign lock_now = shift_en &&
                    (base == CW'(KEY_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key    <= '0;
      cnt    <= '0;
      locked <= 1'b0;
    end else if (shift_en) begin
      key    <= (key << 1) | KEY_W'(key_bit);
      cnt    <= lock_now ? '0 : base + 1'b1;
      locked <= lock_now;
    end
  end

endmodule

// File: rtl/eta_add_sched.sv
// Two-requester round-robin scheduler for a shared key-locked adder.
// Optional ETA_SCHED_KEY_RELOAD_EN: key_vld_i in IDLE restarts key loading.
module eta_add_sched
  import eta_sched_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int KEY_W     = KEY_W_DEF,
  parameter int ADDER_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              key_bit_i,
  input  logic              key_vld_i,
  output logic              key_locked_o,
  input  logic              req0_vld_i,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  output logic              req0_rdy_o,
  input  logic              req1_vld_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  output logic              req1_rdy_o,
  output logic              rsp_vld_o,
  input  logic              rsp_rdy_i,
  output logic              rsp_id_o,
  output logic [DATA_W:0]   rsp_sum_o,
  output logic [DATA_W-1:0] adder_a_o,
  output logic [DATA_W-1:0] adder_b_o,
  output logic [KEY_W-1:0]  adder_key_o,
  input  logic [DATA_W:0]   adder_sum_i
);

  state_e             state;
  logic               ptr;
  logic [LAT_W-1:0]   wcnt;
  logic               gnt0;
  logic               gnt1;
  logic               hs;
  logic               reload;
  logic               lock_now;
  logic [KEY_W-1:0]   key;

`ifdef ETA_SCHED_KEY_RELOAD_EN
  assign reload = (state == IDLE) & key_vld_i;
`else
  assign reload = 1'b0;
`endif

  eta_key_loader #(
    .KEY_W (KEY_W)
  ) u_key (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .key_bit  (key_bit_i),
    .key_vld  (key_vld_i),
    .reload   (reload),
    .key      (key),
    .locked   (key_locked_o),
    .lock_now (lock_now)
  );

  assign adder_key_o = key_locked_o ? key : '0;

  // Pointer side wins a tie; a lone valid requester always wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && key_locked_o && !reload) begin
      unique case (1'b1)
        req0_vld_i && (!ptr || !req1_vld_i): gnt0 = 1'b1;
        req1_vld_i && ( ptr || !req0_vld_i): gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign req0_rdy_o = gnt0;
  assign req1_rdy_o = gnt1;
  assign hs         = gnt0 | gnt1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= KEY_LOAD;
      ptr       <= 1'b0;
      wcnt      <= '0;
      adder_a_o <= '0;
      adder_b_o <= '0;
      rsp_id_o  <= 1'b0;
      rsp_sum_o <= '0;
      rsp_vld_o <= 1'b0;
    end else begin
      unique case (state)
        KEY_LOAD: begin
          if (lock_now) state <= IDLE;
        end
        IDLE: begin
          if (reload) begin
            state <= KEY_LOAD;
          end else if (hs) begin
            adder_a_o <= gnt1 ? req1_a_i : req0_a_i;
            adder_b_o <= gnt1 ? req1_b_i : req0_b_i;
            rsp_id_o  <= gnt1;
            ptr       <= ~gnt1;
            wcnt      <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (wcnt == LAT_W'(ADDER_LAT - 1)) begin
            rsp_sum_o <= adder_sum_i;
            rsp_vld_o <= 1'b1;
            state     <= RESP;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_rdy_i) begin
            rsp_vld_o <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= KEY_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_eta_add_sched.sv
// Randomised bench for eta_add_sched against a transaction-level model.
// Optional ETA_SCHED_KEY_RELOAD_EN selects the reload scenario.
module tb_eta_add_sched;
  import eta_sched_pkg::*;

  localparam int DW  = 16;
  localparam int KW  = 32;
  localparam int LAT = 1;
  localparam logic [31:0] KEY = 32'h93BAF4CF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_bit = 1'b0;
  logic          key_vld = 1'b0;
  logic          key_locked;
  logic [DW-1:0] adder_a;
  logic [DW-1:0] adder_b;
  logic [KW-1:0] adder_key;
  logic [DW:0]   adder_sum;

  eta_add_sched_if #(.DATA_W(DW)) bus ();

  always #5 clk = ~clk;

  assign adder_sum = {1'b0, adder_a} + {1'b0, adder_b};

  eta_add_sched #(
    .DATA_W    (DW),
    .KEY_W     (KW),
    .ADDER_LAT (LAT)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .key_bit_i    (key_bit),
    .key_vld_i    (key_vld),
    .key_locked_o (key_locked),
    .req0_vld_i   (bus.req0_vld),
    .req0_a_i     (bus.req0_a),
    .req0_b_i     (bus.req0_b),
    .req0_rdy_o   (bus.req0_rdy),
    .req1_vld_i   (bus.req1_vld),
    .req1_a_i     (bus.req1_a),
    .req1_b_i     (bus.req1_b),
    .req1_rdy_o   (bus.req1_rdy),
    .rsp_vld_o    (bus.rsp_vld),
    .rsp_rdy_i    (bus.rsp_rdy),
    .rsp_id_o     (bus.rsp_id),
    .rsp_sum_o    (bus.rsp_sum),
    .adder_a_o    (adder_a),
    .adder_b_o    (adder_b),
    .adder_key_o  (adder_key),
    .adder_sum_i  (adder_sum)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  bit          locked_m = 1'b0;
  bit          busy = 1'b0;
  bit          ptr_m = 1'b0;
  bit          hs0 = 1'b0;
  bit          hs1 = 1'b0;
  int          cyc = 0;
  int          due = 0;
  int          nrsp = 0;
  logic        exp_id;
  logic [DW:0] exp_sum;

  // Transaction-level model: round-robin grant, fixed latency, hold.
  always @(negedge clk) begin
    bit e0, e1, idle, rl;
    cyc++;
    hs0 = 1'b0;
    hs1 = 1'b0;
    if (!rst_n) begin
      busy = 1'b0;
      locked_m = 1'b0;
      ptr_m = 1'b0;
      check("rst_ctl", {key_locked, bus.rsp_vld,
                        bus.req0_rdy, bus.req1_rdy}, 0);
      check("rst_key", adder_key, 0);
      check("rst_ops", {adder_a, adder_b}, 0);
      check("rst_sum", bus.rsp_sum, 0);
    end else begin
      idle = locked_m && !busy;
      rl = 1'b0;
`ifdef ETA_SCHED_KEY_RELOAD_EN
      rl = idle && key_vld;
`endif
      e0 = idle && !rl && bus.req0_vld &&
           (!ptr_m || !bus.req1_vld);
      e1 = idle && !rl && bus.req1_vld &&
           (ptr_m || !bus.req0_vld);
      check("grant", {bus.req1_rdy, bus.req0_rdy},
            {e1, e0});
      if (busy) begin
        if (cyc < due) begin
          check("rsp_early", bus.rsp_vld, 0);
        end else begin
          check("rsp_vld", bus.rsp_vld, 1);
          check("rsp_id", bus.rsp_id, exp_id);
          check("rsp_sum", bus.rsp_sum, exp_sum);
          if (bus.rsp_rdy) begin
            busy = 1'b0;
            nrsp++;
          end
        end
      end else begin
        check("rsp_idle", bus.rsp_vld, 0);
      end
      if (e0 || e1) begin
        hs0 = e0;
        hs1 = e1;
        busy = 1'b1;
        due = cyc + LAT + 1;
        exp_id = e1;
        exp_sum = e1 ?
          (DW+1)'(int'(bus.req1_a) + int'(bus.req1_b)) :
          (DW+1)'(int'(bus.req0_a) + int'(bus.req0_b));
        ptr_m = !e1;
      end
      if (rl) locked_m = 1'b0;
    end
  end

  task automatic shift_key(input logic [31:0] k,
                           input int first);
    for (int i = first; i < KW; i++) begin
      @(posedge clk); #1;
      key_vld = 1'b1;
      key_bit = k[KW-1-i];
      @(negedge clk);
      check("key_pre", {key_locked, adder_key}, 0);
    end
    @(posedge clk); #1;
    key_vld = 1'b0;
    locked_m = 1'b1;
    @(negedge clk);
    check("key_lock", key_locked, 1);
    check("key_val", adder_key, k);
  endtask

  task automatic take(input int n);
    bit got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      got = (n != 0) ? bus.req1_rdy : bus.req0_rdy;
    end
    check("take_rdy", got, 1);
    @(posedge clk); #1;
    if (n != 0) bus.req1_vld = 1'b0;
    else bus.req0_vld = 1'b0;
  endtask

  initial begin
    int n0;
    bit seen;
    bus.req0_vld = 1'b0;
    bus.req1_vld = 1'b0;
    bus.req0_a = '0;
    bus.req0_b = '0;
    bus.req1_a = '0;
    bus.req1_b = '0;
    bus.rsp_rdy = 1'b1;

    bus.req0_a = 16'h29AF;
    bus.req0_b = 16'h7A1B;
    bus.req0_vld = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    shift_key(KEY, 0);
    take(0);
    @(negedge clk);
    check("lat_t1", bus.rsp_vld, 0);
    @(negedge clk);
    check("lat_t2", bus.rsp_vld, 1);
    check("first_sum", bus.rsp_sum, 17'h0A3CA);
    check("first_id", bus.rsp_id, 0);

    @(posedge clk); #1;
    bus.req0_a = 16'h1100;
    bus.req0_b = 16'h1111;
    bus.req1_a = 16'h5555;
    bus.req1_b = 16'hAAAA;
    bus.req0_vld = 1'b1;
    bus.req1_vld = 1'b1;
    n0 = nrsp;
    repeat (30) @(posedge clk);
    #1;
    bus.req0_vld = 1'b0;
    bus.req1_vld = 1'b0;
    check("rr_count", (nrsp - n0) >= 8, 1);
    repeat (6) @(posedge clk);

    #1;
    bus.rsp_rdy = 1'b0;
    bus.req1_a = 16'h8943;
    bus.req1_b = 16'hFFFF;
    bus.req1_vld = 1'b1;
    take(1);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = bus.rsp_vld;
    end
    check("hold_seen", seen, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_sum", bus.rsp_sum, 17'h18942);
      check("hold_rdy", {bus.req0_rdy, bus.req1_rdy}, 0);
    end
    @(posedge clk); #1;
    bus.rsp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;

`ifdef ETA_SCHED_KEY_RELOAD_EN
    key_vld = 1'b1;
    key_bit = KEY[31];
    bus.req0_a = 16'h0F0F;
    bus.req0_b = 16'h1234;
    bus.req0_vld = 1'b1;
    @(negedge clk);
    check("reload_rdy", bus.req0_rdy, 0);
    shift_key(KEY, 1);
    take(0);
    repeat (4) @(posedge clk);
    #1;
`else
    for (int k = 0; k < 4; k++) begin
      key_vld = 1'b1;
      key_bit = 1'($urandom);
      @(negedge clk);
      check("ign_lock", key_locked, 1);
      check("ign_key", adder_key, KEY);
      @(posedge clk); #1;
    end
    key_vld = 1'b0;
`endif

    for (int k = 0; k < 300; k++) begin
      bus.rsp_rdy = 1'($urandom_range(0, 1));
      if (!bus.req0_vld || hs0) begin
        bus.req0_vld = 1'($urandom_range(0, 1));
        bus.req0_a = 16'($urandom);
        bus.req0_b = 16'($urandom);
      end
      if (!bus.req1_vld || hs1) begin
        bus.req1_vld = 1'($urandom_range(0, 1));
        bus.req1_a = 16'($urandom);
        bus.req1_b = 16'($urandom);
      end
      @(posedge clk); #1;
    end
    bus.req0_vld = 1'b0;
    bus.req1_vld = 1'b0;
    bus.rsp_rdy = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    bus.req0_a = 16'($urandom);
    bus.req0_b = 16'($urandom);
    bus.req0_vld = 1'b1;
    take(0);
    rst_n = 1'b0;
    @(negedge clk);
    check("wait_rst_vld", bus.rsp_vld, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("no_rsp", bus.rsp_vld, 0);
      check("relock_req", key_locked, 0);
    end
    shift_key(KEY, 0);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
